simple_program_loader: RTL
==========================

# simple_program_loader

Loads a program of control words into the SimpleComputer's instruction memory over a valid/ready stream and holds the CPU halted until loading completes. It drives the write side of the instruction memory that the computer's datapath reads by PC. It also owns the CPU halt line, releasing it only after a complete, well-formed load. It sits between the host/bench stimulus and the instruction-memory write port at the top level.

## Interface
- CW_WIDTH, 13, control-word width (matches CW)
- ADDR_WIDTH, 4, instruction-memory address width (matches PC)
- DEPTH, 16, number of words; must equal 2**ADDR_WIDTH
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- START  input  1  one-cycle pulse: begin a load
- IN_VALID  input  1  IN_WORD/IN_LAST valid
- IN_READY  output  1  loader accepts a word this cycle
- IN_WORD  input  CW_WIDTH  control word to store
- IN_LAST  input  1  marks final program word
- MEM_WE  output  1  instruction-memory write enable
- MEM_ADDR  output  ADDR_WIDTH  write address
- MEM_WDATA  output  CW_WIDTH  write data
- HALT_CPU  output  1  holds PC/CPU stopped
- LOAD_DONE  output  1  program loaded, CPU released
- LOAD_ERR  output  1  load failed
- WORD_COUNT  output  ADDR_WIDTH+1  words written in current/last load

## Operation
- States: IDLE, LOAD, CHECK (macro only), DONE, ERROR.
- Reset: state IDLE; IN_READY=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, HALT_CPU=1, LOAD_DONE=0, LOAD_ERR=0, WORD_COUNT=0, checksum=0. Memory contents untouched.
- IDLE: START -> LOAD; address and WORD_COUNT cleared to 0.
- LOAD: IN_READY=1. Accept = IN_VALID & IN_READY at rising edge. Each accept writes IN_WORD at current address, address+1, WORD_COUNT+1.
  - Accept with IN_LAST=1 -> CHECK (macro) or DONE.
  - Accept at address DEPTH-1 with IN_LAST=0 -> word written, then ERROR (overflow; no wrap).
  - START during LOAD ignored.
- DONE: HALT_CPU=0, LOAD_DONE=1, IN_READY=0. START -> LOAD (HALT_CPU=1, LOAD_DONE=0 next cycle).
- ERROR: HALT_CPU=1, LOAD_ERR=1, IN_READY=0. START -> LOAD, LOAD_ERR cleared.
- WORD_COUNT holds after DONE/ERROR; range 0..DEPTH (width ADDR_WIDTH+1).
- RST mid-load: any in-flight write of that edge is suppressed (MEM_WE=0 next cycle); return to IDLE.

## Timing
- Write latency 1 cycle: MEM_WE/MEM_ADDR/MEM_WDATA registered, valid the cycle after accept; MEM_WE high exactly one cycle per accepted word.
- Back-to-back accepts sustain one word per cycle.
- IN_READY is a function of registered state only (no combinational path from IN_VALID).
- LOAD_DONE/HALT_CPU change the cycle after the final accept (or checksum accept); the final MEM_WE and the release occur in the same cycle.

## Configuration
- LOADER_CHECKSUM_EN defined: after the IN_LAST word, state CHECK keeps IN_READY=1 and accepts one extra word (not written, WORD_COUNT unchanged). Its CW_WIDTH bits are compared with the XOR of all written words: equal -> DONE, else ERROR. IN_LAST on the checksum word is ignored.
- Undefined: no CHECK state, no checksum register; IN_LAST word -> DONE directly.

## Structure
- Shared package: state encoding typedef (IDLE/LOAD/CHECK/DONE/ERROR), default CW_WIDTH/ADDR_WIDTH/DEPTH constants.
- Single module; no sub-module. Bench instantiates a 16x13 memory model alongside it.

## Test plan
- RST held 2 cycles -> HALT_CPU=1, LOAD_DONE=0, LOAD_ERR=0, IN_READY=0, MEM_WE=0, WORD_COUNT=0.
- START, then 4 back-to-back words 0x0A01,0x0B02,0x0C03,0x1FFF (last) -> MEM_WE 4 consecutive cycles at addresses 0..3, WORD_COUNT=4, HALT_CPU=0 and LOAD_DONE=1 one cycle after last accept.
- IN_VALID toggled with gaps during LOAD -> writes only on accepted cycles, addresses contiguous, no duplicate writes.
- 16 words with IN_LAST never set -> addresses 0..15 written, then LOAD_ERR=1, HALT_CPU=1, WORD_COUNT=16; START restarts at address 0.
- RST asserted after 2nd accept of a 5-word load -> no further MEM_WE, state IDLE, HALT_CPU=1; new START loads from address 0.
- With LOADER_CHECKSUM_EN: words 0x0001,0x0002 (last), checksum 0x0003 -> DONE; repeat with checksum 0x0004 -> LOAD_ERR=1, checksum word never written.

Source files
------------

// File: rtl/simple_program_loader_pkg.sv
// simple_program_loader_pkg
//   Shared definitions for the program loader: loader state encoding and
//   the default geometry of the SimpleComputer instruction memory
//   (13-bit control words, 4-bit PC, 16 entries).
//   The CHECK state is only reachable when LOADER_CHECKSUM_EN is defined.
package simple_program_loader_pkg;

  localparam int CW_WIDTH_DEF   = 13;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DEPTH_DEF      = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/simple_program_loader.sv
// simple_program_loader
//   Streams a program of control words into the instruction memory over a
//   valid/ready interface and keeps the CPU halted until a complete,
//   well-formed load has finished.
//
// Configuration macro: LOADER_CHECKSUM_EN
//   Defined   : after the IN_LAST word, one extra checksum word is accepted
//               and compared with the XOR of all written words.
//   Undefined : the IN_LAST word completes the load directly.
//
// Ports
//   CLK         clock, rising edge
//   RST         synchronous active-high reset
//   START       one-cycle pulse, begins a load (ignored while loading)
//   IN_VALID    IN_WORD / IN_LAST valid
//   IN_READY    loader accepts a word this cycle (state-only function)
//   IN_WORD     control word to store
//   IN_LAST     marks the final program word
//   MEM_WE      instruction-memory write enable (registered)
//   MEM_ADDR    instruction-memory write address (registered)
//   MEM_WDATA   instruction-memory write data (registered)
//   HALT_CPU    holds the CPU stopped until a successful load
//   LOAD_DONE   program loaded, CPU released
//   LOAD_ERR    load failed (overflow or checksum mismatch)
//   WORD_COUNT  words written in the current / last load (0..DEPTH)
module simple_program_loader
  import simple_program_loader_pkg::*;
#(
  parameter int CW_WIDTH   = CW_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [CW_WIDTH-1:0]   IN_WORD,
  input  logic                  IN_LAST,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [CW_WIDTH-1:0]   MEM_WDATA,
  output logic                  HALT_CPU,
  output logic                  LOAD_DONE,
  output logic                  LOAD_ERR,
  output logic [ADDR_WIDTH:0]   WORD_COUNT
);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  load_accept;
  logic                  restart;
  logic                  last_slot;

  // IN_READY is high in LOAD, so a valid word there is always accepted.
  assign load_accept = (state == LOAD) && IN_VALID;
  assign restart     = START && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign last_slot   = (wr_addr == ADDR_WIDTH'(DEPTH - 1));

`ifdef LOADER_CHECKSUM_EN
  logic [CW_WIDTH-1:0] checksum;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    IN_READY   = 1'b0;
    HALT_CPU   = 1'b1;
    LOAD_DONE  = 1'b0;
    LOAD_ERR   = 1'b0;
    case (state)
      IDLE: begin
        if (START) state_next = LOAD;
      end
      LOAD: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          if (IN_LAST) begin
`ifdef LOADER_CHECKSUM_EN
            state_next = CHECK;
`else
            state_next = DONE;
`endif
          end else if (last_slot) begin
            // Memory is full and no end marker arrived: no wrap-around.
            state_next = ERROR;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_next = (IN_WORD == checksum) ? DONE : ERROR;
      end
`endif
      DONE: begin
        HALT_CPU  = 1'b0;
        LOAD_DONE = 1'b1;
        if (START) state_next = LOAD;
      end
      ERROR: begin
        LOAD_ERR = 1'b1;
        if (START) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write port and bookkeeping. The reset clears MEM_WE on the same edge, so
  // a word arriving together with RST is never written.
  always_ff @(posedge CLK) begin
    if (RST) begin
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      wr_addr    <= '0;
      WORD_COUNT <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      MEM_WE <= load_accept;
      if (load_accept) begin
        MEM_ADDR   <= wr_addr;
        MEM_WDATA  <= IN_WORD;
        wr_addr    <= wr_addr + 1'b1;
        WORD_COUNT <= WORD_COUNT + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        checksum   <= checksum ^ IN_WORD;
`endif
      end
      if (restart) begin
        wr_addr    <= '0;
        WORD_COUNT <= '0;
`ifdef LOADER_CHECKSUM_EN
        checksum   <= '0;
`endif
      end
    end
  end

endmodule
